lemming_fall_tracker: RTL and testbench
=======================================

LEMMING_FALL_TRACKER -- requirements
Module: lemming_fall_tracker

Interface
REQ-001 Parameter FALL_LIMIT, default 20: longest survivable fall, in cycles.
REQ-002 Parameter STAT_W, default 8: width of the statistics counters.
REQ-003 clk  input  1  rising-edge clock, shared with the upstream lemming walker FSM.
REQ-004 areset  input  1  asynchronous, active-high reset.
REQ-005 walk_left, walk_right, aaah, digging  input  1 each  registered state outputs of the upstream walker FSM.
REQ-006 dead  output  1  lemming has splattered; sticky until reset.
REQ-007 long_fall  output  1  current fall has exceeded FALL_LIMIT cycles.
REQ-008 fall_cnt  output  5  length of the current or most recent fall, in cycles; saturates at 31.
REQ-009 proto_err  output  1  sticky flag: the input encoding was not one-hot.
REQ-010 turn_cnt  output  STAT_W  count of direction reversals.
REQ-011 dig_cnt  output  STAT_W  count of dig starts.

Function
REQ-012 Tracker FSM SHALL have three states: ALIVE, FALLING, DEAD.
REQ-013 ALIVE -> FALLING on any clock edge that samples aaah=1; on that edge fall_cnt SHALL load 1.
REQ-014 FALLING with aaah=1: fall_cnt SHALL increment by 1 per edge and saturate at 31 (no wrap).
REQ-015 FALLING with aaah=0 (landing): next state SHALL be DEAD if fall_cnt > FALL_LIMIT, otherwise ALIVE.
REQ-016 On landing, fall_cnt SHALL hold its value until the next fall starts.
REQ-017 DEAD SHALL be terminal until areset; all inputs SHALL be ignored except by the proto_err check.
REQ-018 In DEAD, fall_cnt, turn_cnt and dig_cnt SHALL freeze.
REQ-019 dead SHALL equal (state==DEAD): 1 the cycle after the landing edge, registered, with no combinational path from inputs.
REQ-020 long_fall SHALL equal (state==FALLING && fall_cnt > FALL_LIMIT), decoded from registers only.
REQ-021 proto_err SHALL set on any edge where {walk_left, walk_right, aaah, digging} is not exactly one-hot (all-zero included).
REQ-022 proto_err SHALL stay set until reset and SHALL be checked in every state.
REQ-023 A fall of exactly FALL_LIMIT cycles SHALL survive; a fall of FALL_LIMIT+1 cycles SHALL be fatal.

Reset
REQ-024 areset SHALL immediately force state=ALIVE and every output to 0, including mid-fall and in DEAD.
REQ-025 The first edge after areset deasserts SHALL be evaluated normally; aaah=1 on that edge starts a fall with fall_cnt=1.

Configuration
REQ-026 Macro LEMMING_FALL_TRACKER_STATS_EN defined: each edge with walk_left=1 whose previous sampled direction was right SHALL increment turn_cnt, and vice versa for walk_right.
REQ-027 The previous direction SHALL be the last of walk_left/walk_right seen, held through falls and digs.
REQ-028 With the macro defined, a rising edge of digging SHALL increment dig_cnt.
REQ-029 With the macro defined, turn_cnt and dig_cnt SHALL wrap modulo 2^STAT_W.
REQ-030 Macro undefined: turn_cnt and dig_cnt SHALL be tied to 0, no counter or history flops SHALL be synthesised, and ports SHALL be unchanged.

Structure
REQ-031 Shared package lemming_pkg SHALL hold the tracker state enum, FALL_CNT_W=5, FALL_CNT_MAX=31 and DEFAULT_FALL_LIMIT=20.
REQ-032 The walker FSM SHALL share lemming_pkg.
REQ-033 The saturating fall counter SHALL be one sub-module, lemming_sat_counter, with width and max as parameters and load1/inc/hold controls.

Verification
REQ-034 From ALIVE, aaah=1 for 20 edges then walk_left=1 -> fall_cnt=20, long_fall never 1, dead=0, state ALIVE.
REQ-035 aaah=1 for 21 edges then ground walk -> long_fall=1 from edge 21, dead=1 one cycle after landing and held for 50 further cycles.
REQ-036 aaah=1 for 40 edges -> fall_cnt stops at 31, then dead=1 after landing; further aaah pulses leave fall_cnt=31.
REQ-037 areset pulsed mid-cycle at fall edge 15 -> dead, long_fall, fall_cnt, proto_err all 0 at once; a following 10-edge fall gives fall_cnt=10 and survives.
REQ-038 walk_left=walk_right=1 for one edge, then one all-zero edge -> proto_err=1 from the first bad edge and held; fall tracking is unaffected.
REQ-039 Macro defined: walk sequence L,R,L,R with two separate digging bursts -> turn_cnt=3, dig_cnt=2. Macro undefined: same stimulus -> both 0.

Source files
------------

// File: rtl/lemming_pkg.sv
// lemming_pkg: types and constants shared by the lemming walker FSM and the fall tracker.
package lemming_pkg;

    localparam int FALL_CNT_W         = 5;
    localparam int FALL_CNT_MAX       = 31;
    localparam int DEFAULT_FALL_LIMIT = 20;

    typedef enum logic [1:0] {
        ALIVE,
        FALLING,
        DEAD
    } tracker_state_t;

    typedef enum logic [2:0] {
        WALK_LEFT,
        WALK_RIGHT,
        FALL_LEFT,
        FALL_RIGHT,
        DIG_LEFT,
        DIG_RIGHT
    } walker_state_t;

endpackage

// File: rtl/lemming_sat_counter.sv
// lemming_sat_counter: saturating up-counter with load-one, increment and hold controls.
// hold_i has top priority, then load1_i, then inc_i.
module lemming_sat_counter #(
    parameter int W   = 5,
    parameter int MAX = 31
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         load1_i,
    input  logic         inc_i,
    input  logic         hold_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = hold_i                     ? cnt_q :
                load1_i                    ? W'(1) :
                (inc_i && cnt_q != MAX_V)  ? cnt_q + W'(1) :
                                             cnt_q;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lemming_fall_tracker.sv
// lemming_fall_tracker: watches the walker FSM outputs, times falls and flags a fatal landing.
// Define LEMMING_FALL_TRACKER_STATS_EN to build the turn/dig statistics counters.
module lemming_fall_tracker
    import lemming_pkg::*;
#(
    parameter int FALL_LIMIT = DEFAULT_FALL_LIMIT,
    parameter int STAT_W     = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              walk_left,
    input  logic              walk_right,
    input  logic              aaah,
    input  logic              digging,
    output logic              dead,
    output logic              long_fall,
    output logic [4:0]        fall_cnt,
    output logic              proto_err,
    output logic [STAT_W-1:0] turn_cnt,
    output logic [STAT_W-1:0] dig_cnt
);

    localparam logic [FALL_CNT_W-1:0] LIMIT_V = FALL_CNT_W'(FALL_LIMIT);

    tracker_state_t        state_q;
    logic                  perr_q;
    logic [FALL_CNT_W-1:0] fall_q;
    logic                  over_limit;

    assign over_limit = fall_q > LIMIT_V;

    // proto_err is evaluated even in DEAD; everything else stops there
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ALIVE;
            perr_q  <= 1'b0;
        end else begin
            if (!$onehot({walk_left, walk_right, aaah, digging})) perr_q <= 1'b1;
            case (state_q)
                ALIVE:   if (aaah) state_q <= FALLING;
                FALLING: if (!aaah) state_q <= over_limit ? DEAD : ALIVE;
                default: state_q <= DEAD;
            endcase
        end
    end

    lemming_sat_counter #(
        .W   (FALL_CNT_W),
        .MAX (FALL_CNT_MAX)
    ) u_fall_cnt (
        .clk     (clk),
        .areset  (areset),
        .load1_i (state_q == ALIVE && aaah),
        .inc_i   (state_q == FALLING && aaah),
        .hold_i  (state_q == DEAD),
        .cnt_o   (fall_q)
    );

    assign dead      = state_q == DEAD;
    assign long_fall = state_q == FALLING && over_limit;
    assign fall_cnt  = fall_q;
    assign proto_err = perr_q;

`ifdef LEMMING_FALL_TRACKER_STATS_EN
    logic              active, turn, dig_start, dir_seen;
    logic [STAT_W-1:0] turn_q, turn_d, dig_q, dig_d;
    logic              dir_vld_q, dir_vld_d, dir_right_q, dir_right_d, dig_prev_q, dig_prev_d;

    assign active    = state_q != DEAD;
    assign dir_seen  = walk_left || walk_right;
    // the direction history survives falls and digs; only a walk updates it
    assign turn      = dir_vld_q && ((walk_left && dir_right_q) || (walk_right && !dir_right_q));
    assign dig_start = digging && !dig_prev_q;

    always_comb begin
        turn_d      = (active && turn)      ? turn_q + STAT_W'(1) : turn_q;
        dig_d       = (active && dig_start) ? dig_q + STAT_W'(1)  : dig_q;
        dir_vld_d   = (active && dir_seen)  ? 1'b1                : dir_vld_q;
        dir_right_d = (active && dir_seen)  ? !walk_left          : dir_right_q;
        dig_prev_d  = active                ? digging             : dig_prev_q;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            turn_q      <= '0;
            dig_q       <= '0;
            dir_vld_q   <= 1'b0;
            dir_right_q <= 1'b0;
            dig_prev_q  <= 1'b0;
        end else begin
            turn_q      <= turn_d;
            dig_q       <= dig_d;
            dir_vld_q   <= dir_vld_d;
            dir_right_q <= dir_right_d;
            dig_prev_q  <= dig_prev_d;
        end
    end

    assign turn_cnt = turn_q;
    assign dig_cnt  = dig_q;
`else
    assign turn_cnt = '0;
    assign dig_cnt  = '0;
`endif

endmodule

// File: tb/tb_lemming_fall_tracker.sv
// tb_lemming_fall_tracker: directed and randomized checks of the fall tracker against a behavioural model.
module tb_lemming_fall_tracker;

    localparam int LIMIT = 20;
`ifdef LEMMING_FALL_TRACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [3:0] L = 4'b1000, R = 4'b0100, A = 4'b0010, D = 4'b0001, Z = 4'b0000;

    logic       clk = 1'b0, areset = 1'b1;
    logic       walk_left = 1'b1, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0;
    logic       dead, long_fall, proto_err;
    logic [4:0] fall_cnt;
    logic [7:0] turn_cnt, dig_cnt;

    int n_checks = 0, n_fail = 0;

    bit m_in_fall, m_dead, m_perr, m_prev_dig;
    int m_fall, m_turn, m_dig, m_last;

    always #5 clk = ~clk;

    lemming_fall_tracker #(.FALL_LIMIT(LIMIT), .STAT_W(8)) dut (
        .clk        (clk),
        .areset     (areset),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .dead       (dead),
        .long_fall  (long_fall),
        .fall_cnt   (fall_cnt),
        .proto_err  (proto_err),
        .turn_cnt   (turn_cnt),
        .dig_cnt    (dig_cnt)
    );

    task automatic model_reset;
        m_in_fall = 0; m_dead = 0; m_perr = 0; m_prev_dig = 0;
        m_fall = 0; m_turn = 0; m_dig = 0; m_last = 0;
    endtask

    // v = {walk_left, walk_right, aaah, digging}; m_last: 0 none, 1 left, 2 right
    task automatic model_step(input logic [3:0] v);
        if ($countones(v) != 1) m_perr = 1;
        if (m_dead) return;
        if (v[1]) begin
            m_fall = m_in_fall ? ((m_fall < 31) ? m_fall + 1 : 31) : 1;
            m_in_fall = 1;
        end else if (m_in_fall) begin
            m_in_fall = 0;
            if (m_fall > LIMIT) m_dead = 1;
        end
        if (v[3] && m_last == 2) m_turn = (m_turn + 1) % 256;
        if (v[2] && m_last == 1) m_turn = (m_turn + 1) % 256;
        if (v[3]) m_last = 1;
        else if (v[2]) m_last = 2;
        if (v[0] && !m_prev_dig) m_dig = (m_dig + 1) % 256;
        m_prev_dig = v[0];
    endtask

    task automatic step(input logic [3:0] v);
        {walk_left, walk_right, aaah, digging} = v;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic assert_reset;
        #2;
        {walk_left, walk_right, aaah, digging} = L;
        areset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset;
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic test_reset;
        assert_reset();
        n_checks++; if (dead !== 1'b0)      begin n_fail++; $display("FAIL reset_dead: got %b need 0", dead); end
        n_checks++; if (long_fall !== 1'b0) begin n_fail++; $display("FAIL reset_long_fall: got %b need 0", long_fall); end
        n_checks++; if (fall_cnt !== 5'd0)  begin n_fail++; $display("FAIL reset_fall_cnt: got %0d need 0", fall_cnt); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b need 0", proto_err); end
        n_checks++; if (turn_cnt !== 8'd0)  begin n_fail++; $display("FAIL reset_turn_cnt: got %0d need 0", turn_cnt); end
        n_checks++; if (dig_cnt !== 8'd0)   begin n_fail++; $display("FAIL reset_dig_cnt: got %0d need 0", dig_cnt); end
        release_reset();
    endtask

    task automatic test_limit_fall;
        assert_reset(); release_reset();
        step(L);
        for (int i = 1; i <= 20; i++) begin
            step(A);
            n_checks++; if (long_fall !== 1'b0) begin n_fail++; $display("FAIL limit_long_fall edge %0d: got %b need 0", i, long_fall); end
        end
        step(L);
        n_checks++; if (fall_cnt !== 5'd20) begin n_fail++; $display("FAIL limit_fall_cnt: got %0d need 20", fall_cnt); end
        n_checks++; if (long_fall !== 1'b0) begin n_fail++; $display("FAIL limit_long_after: got %b need 0", long_fall); end
        step(L);
        n_checks++; if (dead !== 1'b0) begin n_fail++; $display("FAIL limit_dead: got %b need 0", dead); end
        step(A);
        n_checks++; if (fall_cnt !== 5'd1) begin n_fail++; $display("FAIL limit_alive_refall: got %0d need 1", fall_cnt); end
        step(R);
    endtask

    task automatic test_fatal_fall;
        assert_reset(); release_reset();
        for (int i = 1; i <= 21; i++) begin
            step(A);
            n_checks++;
            if (long_fall !== (i == 21)) begin n_fail++; $display("FAIL fatal_long_fall edge %0d: got %b need %b", i, long_fall, i == 21); end
        end
        n_checks++; if (dead !== 1'b0) begin n_fail++; $display("FAIL fatal_dead_before_land: got %b need 0", dead); end
        step(R);
        n_checks++; if (dead !== 1'b1) begin n_fail++; $display("FAIL fatal_dead_after_land: got %b need 1", dead); end
        n_checks++; if (long_fall !== 1'b0) begin n_fail++; $display("FAIL fatal_long_after_land: got %b need 0", long_fall); end
        for (int i = 0; i < 50; i++) begin
            step(($urandom_range(0, 1) == 1) ? A : R);
            n_checks++; if (dead !== 1'b1) begin n_fail++; $display("FAIL fatal_dead_held cycle %0d: got %b need 1", i, dead); end
        end
        n_checks++; if (fall_cnt !== 5'd21) begin n_fail++; $display("FAIL fatal_fall_frozen: got %0d need 21", fall_cnt); end
    endtask

    task automatic test_saturate;
        assert_reset(); release_reset();
        for (int i = 0; i < 40; i++) step(A);
        n_checks++; if (fall_cnt !== 5'd31) begin n_fail++; $display("FAIL sat_fall_cnt: got %0d need 31", fall_cnt); end
        step(L);
        n_checks++; if (dead !== 1'b1) begin n_fail++; $display("FAIL sat_dead: got %b need 1", dead); end
        for (int i = 0; i < 6; i++) begin step(A); step(L); end
        n_checks++; if (fall_cnt !== 5'd31) begin n_fail++; $display("FAIL sat_fall_frozen: got %0d need 31", fall_cnt); end
        assert_reset();
        n_checks++; if (dead !== 1'b0)     begin n_fail++; $display("FAIL sat_reset_dead: got %b need 0", dead); end
        n_checks++; if (fall_cnt !== 5'd0) begin n_fail++; $display("FAIL sat_reset_fall_cnt: got %0d need 0", fall_cnt); end
        release_reset();
    endtask

    task automatic test_reset_mid_fall;
        assert_reset(); release_reset();
        step(Z);
        for (int i = 0; i < 15; i++) step(A);
        assert_reset();
        n_checks++; if (dead !== 1'b0)      begin n_fail++; $display("FAIL mid_dead: got %b need 0", dead); end
        n_checks++; if (long_fall !== 1'b0) begin n_fail++; $display("FAIL mid_long_fall: got %b need 0", long_fall); end
        n_checks++; if (fall_cnt !== 5'd0)  begin n_fail++; $display("FAIL mid_fall_cnt: got %0d need 0", fall_cnt); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_proto_err: got %b need 0", proto_err); end
        release_reset();
        step(A);
        n_checks++; if (fall_cnt !== 5'd1) begin n_fail++; $display("FAIL mid_first_edge: got %0d need 1", fall_cnt); end
        for (int i = 0; i < 9; i++) step(A);
        step(L);
        n_checks++; if (fall_cnt !== 5'd10) begin n_fail++; $display("FAIL mid_fall10_cnt: got %0d need 10", fall_cnt); end
        step(L);
        n_checks++; if (dead !== 1'b0) begin n_fail++; $display("FAIL mid_fall10_dead: got %b need 0", dead); end
    endtask

    task automatic test_proto;
        assert_reset(); release_reset();
        step(L);
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_clean: got %b need 0", proto_err); end
        step(L | R);
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_both_dirs: got %b need 1", proto_err); end
        step(Z);
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_zero: got %b need 1", proto_err); end
        for (int i = 0; i < 5; i++) step(A);
        step(R);
        n_checks++; if (fall_cnt !== 5'd5)  begin n_fail++; $display("FAIL proto_fall_cnt: got %0d need 5", fall_cnt); end
        n_checks++; if (dead !== 1'b0)      begin n_fail++; $display("FAIL proto_dead: got %b need 0", dead); end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_held: got %b need 1", proto_err); end
    endtask

    task automatic test_stats;
        assert_reset(); release_reset();
        step(L); step(D); step(D); step(R); step(L); step(D); step(R);
        n_checks++; if (turn_cnt !== (STATS ? 8'd3 : 8'd0)) begin n_fail++; $display("FAIL stats_turn_cnt: got %0d need %0d", turn_cnt, STATS ? 3 : 0); end
        n_checks++; if (dig_cnt !== (STATS ? 8'd2 : 8'd0))  begin n_fail++; $display("FAIL stats_dig_cnt: got %0d need %0d", dig_cnt, STATS ? 2 : 0); end
    endtask

    task automatic test_random;
        logic [3:0] v;
        for (int s = 0; s < 160; s++) begin
            int k, len, et, ed;
            if (m_dead && $urandom_range(0, 2) == 0) begin assert_reset(); release_reset(); end
            k = $urandom_range(0, 9);
            len = (k <= 3) ? $urandom_range(1, 5) : (k <= 5) ? $urandom_range(1, 4) : (k <= 8) ? $urandom_range(1, 34) : 1;
            for (int i = 0; i < len; i++) begin
                v = (k <= 3) ? (($urandom_range(0, 1) == 1) ? L : R) :
                    (k <= 5) ? D :
                    (k <= 8) ? A :
                    (($urandom_range(0, 1) == 1) ? Z : (A | D));
                step(v);
                et = STATS ? m_turn : 0;
                ed = STATS ? m_dig : 0;
                n_checks++; if (dead !== m_dead) begin n_fail++; $display("FAIL rand_dead seg %0d: got %b need %b", s, dead, m_dead); end
                n_checks++; if (long_fall !== (m_in_fall && m_fall > LIMIT)) begin n_fail++; $display("FAIL rand_long_fall seg %0d: got %b need %b", s, long_fall, m_in_fall && m_fall > LIMIT); end
                n_checks++; if (fall_cnt !== m_fall[4:0]) begin n_fail++; $display("FAIL rand_fall_cnt seg %0d: got %0d need %0d", s, fall_cnt, m_fall); end
                n_checks++; if (proto_err !== m_perr) begin n_fail++; $display("FAIL rand_proto_err seg %0d: got %b need %b", s, proto_err, m_perr); end
                n_checks++; if (turn_cnt !== et[7:0]) begin n_fail++; $display("FAIL rand_turn_cnt seg %0d: got %0d need %0d", s, turn_cnt, et); end
                n_checks++; if (dig_cnt !== ed[7:0]) begin n_fail++; $display("FAIL rand_dig_cnt seg %0d: got %0d need %0d", s, dig_cnt, ed); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_limit_fall();
        test_fatal_fall();
        test_saturate();
        test_reset_mid_fall();
        test_proto();
        test_stats();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
